bin2bcd_disp: RTL and testbench

- Sequential binary-to-packed-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Sits directly upstream of the 8-digit hex scan driver. Its Bcd_out feeds that driver's 32-bit display-data input, so a binary count or measurement shows as decimal digits.
- Uses a start/done handshake. The output register holds the last result, so the display never shows partial conversions.

---
 rtl/dled_pkg.sv | 28 ++
 rtl/bcd_digit_adj.sv | 11 +
 rtl/bin2bcd_disp.sv | 149 ++++++++++++++
 tb/tb_bin2bcd_disp.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dled_pkg.sv
// dled_pkg: shared constants and types for the display-LED data path.
//   DLED_DIGITS / DLED_BIN_W : default digit count and binary input width
//   dled_pow10()             : constant power-of-ten helper for limit math
//   BCD_MAX                  : largest value that fits in DLED_DIGITS digits
//   dled_state_e             : converter FSM state encoding
package dled_pkg;

  localparam int DLED_DIGITS = 8;
  localparam int DLED_BIN_W  = 27;

  function automatic longint unsigned dled_pow10(input int n);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

  localparam longint unsigned BCD_MAX = dled_pow10(DLED_DIGITS) - 64'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } dled_state_e;

endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: double-dabble correction cell for one BCD digit.
//   digit_i : working digit before the shift
//   digit_o : digit_i + 3 when digit_i >= 5, otherwise digit_i
module bcd_digit_adj (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/bin2bcd_disp.sv
// bin2bcd_disp: sequential binary to packed-BCD converter (shift-and-add-3),
// one input bit per clock, feeding the 8-digit scan driver's data input.
//   Clk     : system clock, rising edge
//   Rst_n   : asynchronous active-low reset
//   Start   : conversion request, only looked at in IDLE
//   Bin_in  : unsigned binary value, captured when a conversion starts
//   Busy    : high from the cycle after capture through the DONE cycle
//   Done    : one-cycle pulse in the cycle Bcd_out/Ovf take the new result
//   Bcd_out : packed BCD result, most significant digit at the top
//   Ovf     : captured value did not fit in DIGITS decimal digits
// Optional build macro BIN2BCD_AUTO_CONV_EN: IDLE also starts a conversion
// whenever Bin_in differs from the value last converted.
//
// state | meaning
// IDLE  | waiting for a start request; outputs hold the last result
// SHIFT | one correct-and-shift step per cycle, BIN_W steps in total
// DONE  | result visible on Bcd_out/Ovf, Done pulses, back to IDLE
module bin2bcd_disp
  import dled_pkg::*;
#(
  parameter int BIN_W  = DLED_BIN_W,
  parameter int DIGITS = DLED_DIGITS
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Start,
  input  logic [BIN_W-1:0]      Bin_in,
  output logic                  Busy,
  output logic                  Done,
  output logic [4*DIGITS-1:0]   Bcd_out,
  output logic                  Ovf
);

  localparam int BcdW = 4 * DIGITS;
  localparam int CntW = $clog2(BIN_W + 1);
  localparam longint unsigned BcdMax = dled_pow10(DIGITS) - 64'd1;
  localparam logic [BcdW-1:0] AllNines = {DIGITS{4'h9}};

  dled_state_e      state_q, state_d;
  logic [BIN_W-1:0] shift_q, shift_d;
  logic [BcdW-1:0]  bcd_q, bcd_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             ovf_cap_q, ovf_cap_d;
  logic [BcdW-1:0]  bcd_out_q, bcd_out_d;
  logic             ovf_q, ovf_d;

  logic [BcdW-1:0]  bcd_adj;
  logic [BcdW-1:0]  bcd_shifted;
  logic             ovf_in;
  logic             ovf_now;
  logic             go;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (bcd_q[4*g +: 4]),
      .digit_o (bcd_adj[4*g +: 4])
    );
  end

  assign bcd_shifted = {bcd_adj[BcdW-2:0], shift_q[BIN_W-1]};
  assign ovf_in      = (64'(Bin_in) > BcdMax);
  // A bit carried out of the top digit only happens for values already
  // flagged at capture; folding it in keeps the flag self-consistent.
  assign ovf_now     = ovf_cap_q | bcd_adj[BcdW-1];

`ifdef BIN2BCD_AUTO_CONV_EN
  logic [BIN_W-1:0] last_q, last_d;

  assign go = Start | (Bin_in != last_q);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) last_q <= '0;
    else        last_q <= last_d;
  end

  always_comb begin
    last_d = last_q;
    if (state_q == IDLE && go) last_d = Bin_in;
  end
`else
  assign go = Start;
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      ovf_cap_q <= 1'b0;
      bcd_out_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      ovf_cap_q <= ovf_cap_d;
      bcd_out_q <= bcd_out_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    ovf_cap_d = ovf_cap_q;
    bcd_out_d = bcd_out_q;
    ovf_d     = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          state_d   = SHIFT;
          shift_d   = Bin_in;
          bcd_d     = '0;
          cnt_d     = '0;
          ovf_cap_d = ovf_in;
        end
      end
      SHIFT: begin
        bcd_d     = bcd_shifted;
        shift_d   = {shift_q[BIN_W-2:0], 1'b0};
        cnt_d     = cnt_q + CntW'(1);
        ovf_cap_d = ovf_now;
        // The output register is loaded on the last shift so the new value
        // is already visible during the DONE cycle.
        if (cnt_q == CntW'(BIN_W - 1)) begin
          state_d   = DONE;
          bcd_out_d = ovf_now ? AllNines : bcd_shifted;
          ovf_d     = ovf_now;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign Busy    = (state_q != IDLE);
  assign Done    = (state_q == DONE);
  assign Bcd_out = bcd_out_q;
  assign Ovf     = ovf_q;

endmodule

// File: tb/tb_bin2bcd_disp.sv
module tb_bin2bcd_disp;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b1;
  logic        Start = 1'b0;
  logic [26:0] Bin_in = '0;
  logic        Busy;
  logic        Done;
  logic [31:0] Bcd_out;
  logic        Ovf;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [31:0] bcd;
    logic        ovf;
  } exp_t;

  exp_t q[$];

  bin2bcd_disp dut (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .Start   (Start),
    .Bin_in  (Bin_in),
    .Busy    (Busy),
    .Done    (Done),
    .Bcd_out (Bcd_out),
    .Ovf     (Ovf)
  );

  always #5 Clk = ~Clk;

  function automatic exp_t model(input longint unsigned v);
    exp_t e;
    longint unsigned t;
    t = v;
    e.bcd = '0;
    e.ovf = 1'b0;
    if (v > 64'd99999999) begin
      e.bcd = 32'h99999999;
      e.ovf = 1'b1;
    end else begin
      for (int i = 0; i < 8; i++) begin
        e.bcd[4*i +: 4] = 4'(t % 10);
        t = t / 10;
      end
    end
    return e;
  endfunction

  task automatic check(input string tag, input longint unsigned obs, input longint unsigned exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_conv(input logic [26:0] v, input bit use_start);
    @(negedge Clk);
    Bin_in = v;
    Start  = use_start;
    q.push_back(model(64'(v)));
    @(posedge Clk);
    #1;
    Start = 1'b0;
  endtask

  // Entered one time unit after the accepting edge; returns at the Done
  // sample, or one cycle later when tail is set.
  task automatic finish_conv(input string tag, input int poke_cyc,
                             input logic [26:0] poke_val, input bit tail);
    int          cyc;
    bit          hold_ok;
    bit          busy_ok;
    logic [31:0] prev_bcd;
    logic        prev_ovf;
    logic [26:0] saved;
    exp_t        e;
    cyc      = 1;
    hold_ok  = 1'b1;
    busy_ok  = 1'b1;
    prev_bcd = Bcd_out;
    prev_ovf = Ovf;
    saved    = Bin_in;
    while (Done !== 1'b1 && cyc < 100) begin
      if (Busy !== 1'b1) busy_ok = 1'b0;
      if (Bcd_out !== prev_bcd || Ovf !== prev_ovf) hold_ok = 1'b0;
      if (cyc == poke_cyc) begin
        saved  = Bin_in;
        Start  = 1'b1;
        Bin_in = poke_val;
      end
      @(posedge Clk);
      #1;
      if (cyc == poke_cyc) begin
        Start  = 1'b0;
        Bin_in = saved;
      end
      cyc++;
    end
    check({tag, " latency"}, 64'(cyc), 64'd28);
    check({tag, " busy during"}, 64'(busy_ok), 64'd1);
    check({tag, " output hold"}, 64'(hold_ok), 64'd1);
    check({tag, " busy at done"}, 64'(Busy), 64'd1);
    if (q.size() == 0) begin
      check({tag, " scoreboard empty"}, 64'(q.size()), 64'd1);
    end else begin
      e = q.pop_front();
      check({tag, " bcd"}, 64'(Bcd_out), 64'(e.bcd));
      check({tag, " ovf"}, 64'(Ovf), 64'(e.ovf));
    end
    if (tail) begin
      @(posedge Clk);
      #1;
      check({tag, " done+busy after"}, 64'({Done, Busy}), 64'd0);
    end
  endtask

  initial begin
    int n_done;
    int n_busy;

    // reset state
    #2 Rst_n = 1'b0;
    #1;
    check("rst busy", 64'(Busy), 64'd0);
    check("rst done", 64'(Done), 64'd0);
    check("rst bcd", 64'(Bcd_out), 64'd0);
    check("rst ovf", 64'(Ovf), 64'd0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;

    // basic conversion
    start_conv(27'd12345678, 1'b1);
    finish_conv("c12345678", 0, '0, 1'b1);

    // zero, then back-to-back all-nines
    start_conv(27'd0, 1'b1);
    finish_conv("c0", 0, '0, 1'b0);
    Start  = 1'b1;
    Bin_in = 27'd99999999;
    q.push_back(model(64'd99999999));
    @(posedge Clk);
    #1;
    check("b2b idle slot", 64'({Done, Busy}), 64'd0);
    @(posedge Clk);
    #1;
    check("b2b accepted", 64'(Busy), 64'd1);
    Start = 1'b0;
    finish_conv("c99999999", 0, '0, 1'b1);

    // overflow boundary, then recovery
    start_conv(27'd100000000, 1'b1);
    finish_conv("c100000000", 0, '0, 1'b1);
    start_conv(27'd42, 1'b1);
    finish_conv("c42", 0, '0, 1'b1);

    // start during busy ignored
    start_conv(27'd250, 1'b1);
    finish_conv("c250", 5, 27'd7, 1'b1);
    n_done = 0;
    repeat (35) begin
      @(posedge Clk);
      #1;
      if (Done === 1'b1) n_done++;
    end
    check("ignored start extra done", 64'(n_done), 64'd0);

    // largest input value
    start_conv(27'h7FFFFFF, 1'b1);
    finish_conv("cmax", 0, '0, 1'b1);

    // reset mid-conversion
    start_conv(27'd12345, 1'b1);
    repeat (9) begin
      @(posedge Clk);
      #1;
    end
    check("pre-rst busy", 64'(Busy), 64'd1);
    #2 Rst_n = 1'b0;
    #1;
    check("midrst outputs", 64'({Busy, Done, Ovf, Bcd_out}), 64'd0);
    void'(q.pop_back());
    Bin_in = '0;
    @(negedge Clk);
    Rst_n = 1'b1;
    n_done = 0;
    n_busy = 0;
    repeat (40) begin
      @(posedge Clk);
      #1;
      if (Done === 1'b1) n_done++;
      if (Busy === 1'b1) n_busy++;
    end
    check("post-rst done", 64'(n_done), 64'd0);
    check("post-rst busy", 64'(n_busy), 64'd0);
    check("post-rst bcd", 64'(Bcd_out), 64'd0);

`ifdef BIN2BCD_AUTO_CONV_EN
    start_conv(27'd5, 1'b0);
    finish_conv("auto5", 0, '0, 1'b1);
    n_busy = 0;
    repeat (40) begin
      @(posedge Clk);
      #1;
      if (Busy === 1'b1) n_busy++;
    end
    check("auto steady", 64'(n_busy), 64'd0);
    start_conv(27'd1234, 1'b0);
    finish_conv("auto1234", 0, '0, 1'b1);
`else
    @(negedge Clk);
    Bin_in = 27'd5;
    n_busy = 0;
    repeat (40) begin
      @(posedge Clk);
      #1;
      if (Busy === 1'b1) n_busy++;
    end
    check("no auto start", 64'(n_busy), 64'd0);
`endif

    check("scoreboard drained", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
